// File: rtl/dct_transpose_8x8_if.sv
// Row-in / column-out handshake bundle for the 8x8 DCT transpose buffer.
// The producer/consumer side is the master; the transpose block is the slave.
interface dct_transpose_8x8_if #(
  parameter int unsigned IN_W = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [IN_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [2:0]             out_col;
  logic                   out_last;

  modport master (
    output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    input  in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7,
           out_col, out_last
  );

  modport slave (
    input  in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7,
           out_col, out_last
  );
endinterface

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between two 1-D DCT row stages:
// accepts 8 rows into one bank while the other bank is emitted column by column.
module dct_transpose_8x8 #(
  parameter int unsigned IN_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  dct_transpose_8x8_if.slave bus
);
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic signed [IN_W-1:0] word_t;

  word_t            bank_q [2][N][N];
  word_t            row_in [N];
  word_t            col_out[N];

  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d;
  logic [IDX_W-1:0] rd_col_q, rd_col_d;
  logic             wr_en;
  logic             rd_en;

  always_comb begin
    row_in[0] = bus.in0;
    row_in[1] = bus.in1;
    row_in[2] = bus.in2;
    row_in[3] = bus.in3;
    row_in[4] = bus.in4;
    row_in[5] = bus.in5;
    row_in[6] = bus.in6;
    row_in[7] = bus.in7;
  end

  // Write and read never target the same bank, so both flag updates can land on one edge.
  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    rd_col_d    = rd_col_q;
    wr_en       = bus.in_valid && !bank_full_q[wr_bank_q];
    rd_en       = bank_full_q[rd_bank_q] && bus.out_ready;

    if (wr_en) begin
      wr_row_d = wr_row_q + IDX_W'(1);
      if (wr_row_q == IDX_W'(N - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end

    if (rd_en) begin
      rd_col_d = rd_col_q + IDX_W'(1);
      if (rd_col_q == IDX_W'(N - 1)) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      rd_col_q    <= rd_col_d;
    end
  end

  // Sample storage carries no reset; its contents are only visible behind bank_full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        bank_q[wr_bank_q][wr_row_q][k] <= row_in[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      col_out[k] = bank_q[rd_bank_q][k][rd_col_q];
    end
  end

  assign bus.in_ready  = !bank_full_q[wr_bank_q];
  assign bus.out_valid = bank_full_q[rd_bank_q];
  assign bus.out_col   = rd_col_q;
  assign bus.out_last  = bank_full_q[rd_bank_q] && (rd_col_q == IDX_W'(N - 1));
  assign bus.out0      = col_out[0];
  assign bus.out1      = col_out[1];
  assign bus.out2      = col_out[2];
  assign bus.out3      = col_out[3];
  assign bus.out4      = col_out[4];
  assign bus.out5      = col_out[5];
  assign bus.out6      = col_out[6];
  assign bus.out7      = col_out[7];
endmodule
